// File: rtl/gst_shifter_pkg.sv
// Shared definitions for the GST pixel serializer: resolution modes,
// plane counts and the 3:3:3 RGB colour type.
package gst_shifter_pkg;

  typedef enum logic [1:0] {
    MODE_LOW  = 2'b00,
    MODE_MED  = 2'b01,
    MODE_HIGH = 2'b10
  } mode_e;

  localparam int unsigned RGB_CW    = 3;
  localparam int unsigned RGB_W     = 3 * RGB_CW;
  localparam int unsigned PAL_DEPTH = 16;
  localparam int unsigned PAL_AW    = 4;

  typedef logic [RGB_W-1:0] rgb333_t;

  // mde1 set selects high resolution regardless of mde0
  function automatic mode_e decode_mode(input logic [1:0] mde);
    if (mde[1])
      return MODE_HIGH;
    else if (mde[0])
      return MODE_MED;
    else
      return MODE_LOW;
  endfunction

  function automatic logic [2:0] nplanes(input mode_e mode);
    case (mode)
      MODE_LOW: return 3'd4;
      MODE_MED: return 3'd2;
      default:  return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/gst_palette.sv
// 16-entry ST colour palette: one synchronous write port, combinational
// reads of an indexed entry and of entry 0 (used for mono polarity/border).
module gst_palette
  import gst_shifter_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_resb,
  input  logic              i_we,
  input  logic [PAL_AW-1:0] i_addr,
  input  rgb333_t           i_din,
  input  logic [PAL_AW-1:0] i_rd_addr,
  output rgb333_t           o_rd_data,
  output rgb333_t           o_rd0_data
);

  rgb333_t r_mem [PAL_DEPTH];

  always_ff @(posedge i_clk or negedge i_resb) begin
    if (!i_resb) begin
      for (int unsigned i = 0; i < PAL_DEPTH; i++)
        r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_addr] <= i_din;
    end
  end

  assign o_rd_data  = r_mem[i_rd_addr];
  assign o_rd0_data = r_mem[0];

endmodule

// File: rtl/gst_shifter.sv
// GST pixel serializer: latches bitplane words on dcyc, loads shifters on
// sload, serializes at the mode's pixel rate and drives blanked RGB333.
module gst_shifter
  import gst_shifter_pkg::*;
#(
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          resb,
  input  logic          mde0,
  input  logic          mde1,
  input  logic [DW-1:0] din,
  input  logic          dcyc_n,
  input  logic          sload_n,
  input  logic          de,
  input  logic          blank_n,
  input  logic          pal_we,
  input  logic [3:0]    pal_addr,
  input  logic [8:0]    pal_din,
  output logic [2:0]    r,
  output logic [2:0]    g,
  output logic [2:0]    b
);

  logic          r_dcyc_prev;
  logic          r_sload_prev;
  logic [1:0]    r_mde;
  logic [DW-1:0] r_ir [4];
  logic [DW-1:0] r_sr [4];
  logic [1:0]    r_pcnt;
  logic [1:0]    r_div;
  rgb333_t       r_rgb;

  mode_e         w_mode;
  logic          w_dcyc_ev;
  logic          w_sload_ev;
  logic          w_mode_chg;
  logic          w_pe;
  logic [2:0]    w_np;
  logic [2:0]    w_pcnt_inc;
  logic [1:0]    w_ir_sel;
  logic [3:0]    w_idx;
  logic          w_mono;
  rgb333_t       w_pal_idx;
  rgb333_t       w_pal0;
  rgb333_t       w_color;

  assign w_mode     = decode_mode({mde1, mde0});
  assign w_np       = nplanes(w_mode);
  assign w_dcyc_ev  = !dcyc_n && r_dcyc_prev;
  assign w_sload_ev = !sload_n && r_sload_prev;
  assign w_mode_chg = ({mde1, mde0} != r_mde);
  assign w_pcnt_inc = {1'b0, r_pcnt} + 3'd1;
  // A word arriving together with sload belongs to the next line's plane 0
  assign w_ir_sel   = w_sload_ev ? 2'd0 : r_pcnt;

  always_comb begin
    w_pe = 1'b1;
    case (w_mode)
      MODE_LOW: w_pe = (r_div == 2'd3);
      MODE_MED: w_pe = r_div[0];
      default:  w_pe = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      r_dcyc_prev  <= 1'b1;
      r_sload_prev <= 1'b1;
      r_mde        <= '0;
      r_pcnt       <= '0;
      r_div        <= '0;
      for (int unsigned p = 0; p < 4; p++) begin
        r_ir[p] <= '0;
        r_sr[p] <= '0;
      end
    end else begin
      r_dcyc_prev  <= dcyc_n;
      r_sload_prev <= sload_n;
      r_mde        <= {mde1, mde0};
      r_div        <= w_sload_ev ? 2'd0 : r_div + 2'd1;

      for (int unsigned p = 0; p < 4; p++) begin
        if (w_sload_ev)
          r_sr[p] <= r_ir[p];
        else if (w_pe)
          r_sr[p] <= {r_sr[p][DW-2:0], 1'b0};
      end

      if (w_dcyc_ev)
        r_ir[w_ir_sel] <= din;

      if (w_sload_ev)
        r_pcnt <= (w_dcyc_ev && w_np != 3'd1) ? 2'd1 : 2'd0;
      else if (w_mode_chg)
        r_pcnt <= '0;
      else if (w_dcyc_ev)
        r_pcnt <= (w_pcnt_inc >= w_np) ? 2'd0 : w_pcnt_inc[1:0];
    end
  end

  always_comb begin
    w_idx = '0;
    case (w_mode)
      MODE_LOW: w_idx = {r_sr[3][DW-1], r_sr[2][DW-1], r_sr[1][DW-1], r_sr[0][DW-1]};
      MODE_MED: w_idx = {2'b00, r_sr[1][DW-1], r_sr[0][DW-1]};
      default:  w_idx = '0;
    endcase
    if (!de)
      w_idx = '0;
  end

  gst_palette u_palette (
    .i_clk      (clk),
    .i_resb     (resb),
    .i_we       (pal_we),
    .i_addr     (pal_addr),
    .i_din      (pal_din),
    .i_rd_addr  (w_idx),
    .o_rd_data  (w_pal_idx),
    .o_rd0_data (w_pal0)
  );

  // Mono: set pixel is black, palette entry 0 bit 0 inverts polarity
  always_comb begin
    w_mono  = de ? (r_sr[0][DW-1] ^ w_pal0[0]) : w_pal0[0];
    w_color = w_pal_idx;
    if (w_mode == MODE_HIGH)
      w_color = w_mono ? '0 : '1;
  end

  always_ff @(posedge clk or negedge resb) begin
    if (!resb)
      r_rgb <= '0;
    else
      r_rgb <= blank_n ? w_color : '0;
  end

  assign r = r_rgb[8:6];
  assign g = r_rgb[5:3];
  assign b = r_rgb[2:0];

endmodule

// File: tb/tb_gst_shifter.sv
// Directed self-checking bench for gst_shifter with hand-computed colours.
module tb_gst_shifter;

  logic        clk = 1'b0;
  logic        resb;
  logic        mde0;
  logic        mde1;
  logic [15:0] din;
  logic        dcyc_n;
  logic        sload_n;
  logic        de;
  logic        blank_n;
  logic        pal_we;
  logic [3:0]  pal_addr;
  logic [8:0]  pal_din;
  logic [2:0]  r;
  logic [2:0]  g;
  logic [2:0]  b;
  logic [8:0]  w_rgb;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  assign w_rgb = {r, g, b};

  gst_shifter #(.DW(16)) dut (
    .clk      (clk),
    .resb     (resb),
    .mde0     (mde0),
    .mde1     (mde1),
    .din      (din),
    .dcyc_n   (dcyc_n),
    .sload_n  (sload_n),
    .de       (de),
    .blank_n  (blank_n),
    .pal_we   (pal_we),
    .pal_addr (pal_addr),
    .pal_din  (pal_din),
    .r        (r),
    .g        (g),
    .b        (b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pal_write(input logic [3:0] a, input logic [8:0] d);
    pal_addr = a;
    pal_din  = d;
    pal_we   = 1'b1;
    step();
    pal_we   = 1'b0;
  endtask

  task automatic dcyc(input logic [15:0] w);
    din    = w;
    dcyc_n = 1'b0;
    step();
    dcyc_n = 1'b1;
    step();
  endtask

  // Returns just after the edge on which the sload event fires
  task automatic sload();
    sload_n = 1'b0;
    step();
    sload_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    resb = 1'b0; mde0 = 1'b0; mde1 = 1'b0; din = '0;
    dcyc_n = 1'b1; sload_n = 1'b0; de = 1'b1; blank_n = 1'b1;
    pal_we = 1'b0; pal_addr = '0; pal_din = '0;

    repeat (3) step();
    check("reset_rgb", w_rgb, 9'h000);
    check("reset_pcnt", dut.r_pcnt, 2'd0);
    resb = 1'b1;
    step();

    // Low res, sload held low from reset: no load until it goes 1->0
    pal_write(4'd15, 9'h1FF);
    for (int i = 0; i < 4; i++) begin
      dcyc(16'h8000);
      check("lo_pcnt", dut.r_pcnt, (i + 1) % 4);
    end
    step();
    check("lo_no_load", w_rgb, 9'h000);
    sload_n = 1'b1;
    step();
    sload();
    check("lo_edgeN", w_rgb, 9'h000);
    check("lo_pcnt_sload", dut.r_pcnt, 2'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("lo_px15", w_rgb, 9'h1FF);
    end
    step();
    check("lo_px14", w_rgb, 9'h000);

    // Medium res
    dcyc(16'h0000);
    check("lo_pcnt_pre_chg", dut.r_pcnt, 2'd1);
    mde0 = 1'b1;
    step();
    check("mode_chg_pcnt", dut.r_pcnt, 2'd0);
    dcyc(16'hFFFF);
    check("md_pcnt1", dut.r_pcnt, 2'd1);
    dcyc(16'h0000);
    check("md_pcnt_wrap", dut.r_pcnt, 2'd0);
    pal_write(4'd1, 9'h049);
    sload();
    for (int k = 0; k < 32; k++) begin
      step();
      check("md_px", w_rgb, 9'h049);
    end
    step();
    check("md_after", w_rgb, 9'h000);

    // High res mono, normal then inverted polarity
    mde1 = 1'b1;
    step();
    dcyc(16'hAAAA);
    check("hi_pcnt", dut.r_pcnt, 2'd0);
    sload();
    for (int k = 0; k < 16; k++) begin
      step();
      check("hi_px", w_rgb, (k % 2 == 0) ? 9'h000 : 9'h1FF);
    end
    pal_write(4'd0, 9'h001);
    sload();
    for (int k = 0; k < 16; k++) begin
      step();
      check("hi_inv_px", w_rgb, (k % 2 == 0) ? 9'h1FF : 9'h000);
    end
    de = 1'b0;
    step();
    check("hi_border", w_rgb, 9'h000);
    de = 1'b1;

    // Simultaneous dcyc + sload in low res
    mde1 = 1'b0;
    mde0 = 1'b0;
    step();
    for (int i = 0; i < 4; i++)
      dcyc(16'h8000);
    pal_write(4'd4, 9'h124);
    din = 16'h0000;
    dcyc_n = 1'b0;
    sload_n = 1'b0;
    step();
    check("sim_pcnt1", dut.r_pcnt, 2'd1);
    dcyc_n = 1'b1;
    sload_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("sim_old_px", w_rgb, 9'h1FF);
    end
    step();
    check("sim_after", w_rgb, 9'h001);
    dcyc(16'h0000);
    check("sim_pcnt2", dut.r_pcnt, 2'd2);
    dcyc(16'h8000);
    check("sim_pcnt3", dut.r_pcnt, 2'd3);
    dcyc(16'h0000);
    check("sim_pcnt0", dut.r_pcnt, 2'd0);
    sload();
    step();
    check("sim_new_px", w_rgb, 9'h124);

    // Border, blanking, mid-line palette write
    pal_write(4'd0, 9'h038);
    de = 1'b0;
    step();
    check("border", w_rgb, 9'h038);
    blank_n = 1'b0;
    step();
    check("blank", w_rgb, 9'h000);
    blank_n = 1'b1;
    step();
    check("unblank", w_rgb, 9'h038);
    pal_write(4'd0, 9'h1C0);
    check("pal_wr_old", w_rgb, 9'h038);
    step();
    check("pal_wr_new", w_rgb, 9'h1C0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
